// File: rtl/data_memory_bytewise.sv
// Byte-addressed data memory for the single-cycle MIPS datapath.
// Sub-word loads/stores, misalignment detection and a post-reset clear sequencer.
module data_memory_bytewise #(
  parameter int NBITS      = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int TEST_WORD  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [1:0]       size,
  input  logic             uns,
  input  logic [NBITS-1:0] A,
  input  logic [NBITS-1:0] WD,
  output logic [NBITS-1:0] RD,
  output logic             busy,
  output logic             err,
  output logic [15:0]      test_valu
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_clr_cnt;
  logic [DEPTH_LOG2-1:0] w_clr_cnt_nxt;
  logic                  w_clear_en;

  logic [NBITS-1:0]      r_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_lane;
  logic                  w_misal;
  logic                  w_store;
  logic [3:0]            w_be;
  logic [NBITS-1:0]      w_wdata;
  logic [NBITS-1:0]      w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [NBITS-1:0]      w_rd;
  logic                  w_unused;

  assign w_idx    = A[DEPTH_LOG2+1:2];
  assign w_lane   = A[1:0];
  assign w_unused = &{1'b0, A[NBITS-1:DEPTH_LOG2+2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clear_en    = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        w_clear_en    = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (&r_clr_cnt) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  assign busy = (r_state == ST_CLEAR);

  always_comb begin
    w_misal = 1'b0;
    unique case (size)
      2'b00:   w_misal = 1'b0;
      2'b01:   w_misal = A[0];
      2'b10:   w_misal = |A[1:0];
      default: w_misal = 1'b1;
    endcase
  end

  assign err     = (we | re) & ~busy & w_misal;
  assign w_store = we & ~busy & ~w_misal;

  // Replicate store data across lanes so each enabled lane takes its own slice.
  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    unique case (size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{WD[7:0]}};
      end
      2'b01: begin
        w_be    = A[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WD[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wdata = WD;
      end
      default: begin
        w_be    = '0;
        w_wdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clear_en) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign w_word = r_mem[w_idx];

  always_comb begin
    w_byte = '0;
    unique case (w_lane)
      2'b00: w_byte = w_word[7:0];
      2'b01: w_byte = w_word[15:8];
      2'b10: w_byte = w_word[23:16];
      2'b11: w_byte = w_word[31:24];
      default: w_byte = '0;
    endcase
  end

  assign w_half = A[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_rd = '0;
    unique case (size)
      2'b00: begin
        w_rd = uns ? {{(NBITS-8){1'b0}}, w_byte}
                   : {{(NBITS-8){w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_rd = uns ? {{(NBITS-16){1'b0}}, w_half}
                   : {{(NBITS-16){w_half[15]}}, w_half};
      end
      2'b10: begin
        w_rd = w_word;
      end
      default: begin
        w_rd = '0;
      end
    endcase
  end

  assign RD        = (busy | err) ? '0 : w_rd;
  assign test_valu = r_mem[TEST_WORD][15:0];

endmodule

// File: tb/tb_data_memory_bytewise.sv
// Scoreboard bench for data_memory_bytewise: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_data_memory_bytewise;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        re;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        busy;
  logic        err;
  logic [15:0] test_valu;

  always #5 clk = ~clk;

  data_memory_bytewise dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .re        (re),
    .size      (size),
    .uns       (uns),
    .A         (A),
    .WD        (WD),
    .RD        (RD),
    .busy      (busy),
    .err       (err),
    .test_valu (test_valu)
  );

  localparam logic [3:0] M_RD = 4'b0001;
  localparam logic [3:0] M_ER = 4'b0010;
  localparam logic [3:0] M_BS = 4'b0100;
  localparam logic [3:0] M_TV = 4'b1000;

  typedef struct {
    string       nm;
    logic [3:0]  m;
    logic [31:0] rd;
    logic        er;
    logic        bs;
    logic [15:0] tv;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic drv(input logic w, input logic r, input logic [1:0] s,
                     input logic u, input logic [31:0] a,
                     input logic [31:0] d);
    we = w; re = r; size = s; uns = u; A = a; WD = d;
  endtask

  task automatic expect_e(input string nm, input logic [3:0] m,
                          input logic [31:0] rd, input logic er,
                          input logic bs, input logic [15:0] tv);
    exp_t e;
    e.nm = nm; e.m = m; e.rd = rd; e.er = er; e.bs = bs; e.tv = tv;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) begin
        total++;
        if (RD !== e.rd) begin
          bad++;
          $display("FAIL %s RD got=%h want=%h", e.nm, RD, e.rd);
        end
      end
      if (e.m[1]) begin
        total++;
        if (err !== e.er) begin
          bad++;
          $display("FAIL %s err got=%b want=%b", e.nm, err, e.er);
        end
      end
      if (e.m[2]) begin
        total++;
        if (busy !== e.bs) begin
          bad++;
          $display("FAIL %s busy got=%b want=%b", e.nm, busy, e.bs);
        end
      end
      if (e.m[3]) begin
        total++;
        if (test_valu !== e.tv) begin
          bad++;
          $display("FAIL %s test_valu got=%h want=%h", e.nm, test_valu, e.tv);
        end
      end
    end
  end

  task automatic clear_phase(input bit busy_store);
    for (int i = 0; i < 256; i++) begin
      if (busy_store && i == 2) begin
        drv(1, 1, 2'b10, 0, 32'h0, 32'h11112222);
        expect_e("busy_sw", M_RD | M_ER | M_BS, 32'h0, 0, 1, 16'h0);
      end else begin
        drv(0, 1, 2'b10, 0, 32'h3, 32'h0);
        expect_e("clear_busy", M_RD | M_ER | M_BS, 32'h0, 0, 1, 16'h0);
      end
      tick();
    end
    drv(0, 0, 2'b10, 0, 32'h0, 32'h0);
    expect_e("clear_end", M_BS | M_TV, 32'h0, 0, 0, 16'h0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drv(1, 1, 2'b10, 0, 32'h3, 32'hFFFFFFFF);
    #1;
    expect_e("rst", M_RD | M_ER | M_BS, 32'h0, 0, 1, 16'h0);
    tick();
    tick();
    reset = 1'b0;
    clear_phase(1);

    drv(0, 1, 2'b10, 0, 32'h0, 32'h0);
    expect_e("t6_w0", M_RD | M_ER | M_TV, 32'h0, 0, 0, 16'h0);
    tick();
    drv(1, 0, 2'b10, 0, 32'h0, 32'h11112222);
    expect_e("t6_sw", M_ER, 32'h0, 0, 0, 16'h0);
    tick();
    drv(0, 1, 2'b10, 0, 32'h0, 32'h0);
    expect_e("t6_tv", M_RD | M_TV, 32'h11112222, 0, 0, 16'h2222);
    tick();

    drv(1, 0, 2'b10, 0, 32'h14, 32'h55555555);
    tick();
    drv(0, 1, 2'b10, 0, 32'h14, 32'h0);
    expect_e("w5", M_RD | M_ER, 32'h55555555, 0, 0, 16'h0);
    tick();

    reset = 1'b1;
    #1;
    expect_e("rst_mid0", M_RD | M_BS, 32'h0, 0, 1, 16'h0);
    tick();
    expect_e("rst_mid1", M_RD | M_BS, 32'h0, 0, 1, 16'h0);
    tick();
    reset = 1'b0;
    clear_phase(0);

    drv(0, 1, 2'b10, 0, 32'h14, 32'h0);
    expect_e("t1_w5", M_RD | M_ER | M_TV, 32'h0, 0, 0, 16'h0);
    tick();
    drv(1, 0, 2'b10, 0, 32'h0, 32'h11112222);
    tick();

    drv(1, 1, 2'b10, 0, 32'h4, 32'hDEADBEEF);
    expect_e("t2_sw_pre", M_RD | M_ER, 32'h0, 0, 0, 16'h0);
    tick();
    drv(0, 1, 2'b10, 0, 32'h4, 32'h0);
    expect_e("t2_lw", M_RD | M_ER, 32'hDEADBEEF, 0, 0, 16'h0);
    tick();
    drv(0, 1, 2'b10, 0, 32'h404, 32'h0);
    expect_e("t2_alias", M_RD | M_ER, 32'hDEADBEEF, 0, 0, 16'h0);
    tick();

    drv(1, 0, 2'b10, 0, 32'h8, 32'h0);
    tick();
    drv(1, 0, 2'b00, 0, 32'hB, 32'h80);
    tick();
    drv(0, 1, 2'b10, 0, 32'h8, 32'h0);
    expect_e("t3_lw", M_RD | M_ER, 32'h80000000, 0, 0, 16'h0);
    tick();
    drv(0, 1, 2'b00, 0, 32'hB, 32'h0);
    expect_e("t3_lb", M_RD | M_ER, 32'hFFFFFF80, 0, 0, 16'h0);
    tick();
    drv(0, 1, 2'b00, 1, 32'hB, 32'h0);
    expect_e("t3_lbu", M_RD | M_ER, 32'h00000080, 0, 0, 16'h0);
    tick();

    drv(1, 0, 2'b01, 0, 32'hE, 32'h1234ABCD);
    tick();
    drv(0, 1, 2'b10, 0, 32'hC, 32'h0);
    expect_e("t4_lw", M_RD | M_ER, 32'hABCD0000, 0, 0, 16'h0);
    tick();
    drv(0, 1, 2'b01, 0, 32'hE, 32'h0);
    expect_e("t4_lh", M_RD | M_ER, 32'hFFFFABCD, 0, 0, 16'h0);
    tick();
    drv(0, 1, 2'b01, 1, 32'hE, 32'h0);
    expect_e("t4_lhu", M_RD | M_ER, 32'h0000ABCD, 0, 0, 16'h0);
    tick();
    drv(0, 1, 2'b01, 0, 32'hC, 32'h0);
    expect_e("t4_lh_lo", M_RD | M_ER, 32'h0, 0, 0, 16'h0);
    tick();

    drv(1, 0, 2'b10, 0, 32'h6, 32'hCAFEBABE);
    expect_e("t5_sw_mis", M_RD | M_ER, 32'h0, 1, 0, 16'h0);
    tick();
    drv(0, 1, 2'b10, 0, 32'h4, 32'h0);
    expect_e("t5_w1", M_RD | M_ER, 32'hDEADBEEF, 0, 0, 16'h0);
    tick();
    drv(0, 1, 2'b01, 0, 32'h3, 32'h0);
    expect_e("t5_lh_mis", M_RD | M_ER, 32'h0, 1, 0, 16'h0);
    tick();
    drv(0, 1, 2'b11, 0, 32'h0, 32'h0);
    expect_e("t5_rsv", M_RD | M_ER, 32'h0, 1, 0, 16'h0);
    tick();
    drv(0, 0, 2'b10, 0, 32'h3, 32'h0);
    expect_e("t5_idle", M_ER, 32'h0, 0, 0, 16'h0);
    tick();
    drv(0, 1, 2'b00, 1, 32'h3, 32'h0);
    expect_e("t5_lbu3", M_RD | M_ER, 32'h00000011, 0, 0, 16'h0);
    tick();
    drv(1, 0, 2'b11, 0, 32'h0, 32'hFFFFFFFF);
    expect_e("rsv_sw", M_RD | M_ER, 32'h0, 1, 0, 16'h0);
    tick();
    drv(0, 1, 2'b10, 0, 32'h0, 32'h0);
    expect_e("rsv_keep", M_RD | M_TV, 32'h11112222, 0, 0, 16'h2222);
    tick();

    drv(1, 0, 2'b10, 0, 32'h3FC, 32'hA5A5A5A5);
    tick();
    drv(0, 1, 2'b10, 0, 32'hFFFFFFFC, 32'h0);
    expect_e("top_wrap", M_RD | M_ER, 32'hA5A5A5A5, 0, 0, 16'h0);
    tick();
    drv(0, 1, 2'b10, 0, 32'h0, 32'h0);
    expect_e("w0_keep", M_RD | M_TV, 32'h11112222, 0, 0, 16'h2222);
    tick();

    drv(0, 0, 2'b10, 0, 32'h0, 32'h0);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
